// File: rtl/regfile_sb.sv
// Integer register file for the Pillar core: NREAD combinational read ports, one
// write port with optional bypass, pending-write scoreboard and a reset-free array.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  output logic                      ready_o,
  input  logic [NREAD*$clog2(NREGS)-1:0] rs_i,
  output logic [NREAD*XLEN-1:0]     rdata_o,
  output logic [NREAD-1:0]          hazard_o,
  input  logic                      we_i,
  input  logic [$clog2(NREGS)-1:0]  rd_i,
  input  logic [XLEN-1:0]           wd_i,
  input  logic                      rsv_i,
  input  logic [$clog2(NREGS)-1:0]  rsv_rd_i
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NREGS-1:0]  pend_q, pend_d;

  logic [XLEN-1:0]   mem [NREGS];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic [AW-1:0]     rs_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      idx_q   <= AW'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // The sweep and the write port share the single array write path, so the
  // storage stays a plain one-write-port memory with no reset.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = '0;
    case (state_q)
      CLEAR: begin
        mem_we        = 1'b1;
        pend_d[idx_q] = 1'b0;
        idx_d         = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) state_d = READY;
        if (clear_i) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end
      end
      READY: begin
        if (clear_i) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
          pend_d  = '0;
        end else begin
          if (we_i && rd_i != '0) begin
            mem_we       = 1'b1;
            mem_waddr    = rd_i;
            mem_wdata    = wd_i;
            pend_d[rd_i] = 1'b0;
          end
          // Reserve is applied after the write so a new producer wins.
          if (rsv_i && rsv_rd_i != '0) pend_d[rsv_rd_i] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ready_o = (state_q == READY);

  always_comb begin
    rdata_o  = '0;
    hazard_o = '0;
    rs_idx   = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs_idx = rs_i[p*AW +: AW];
      if (state_q == READY && rs_idx != '0) begin
        if (BYPASS != 0 && we_i && rd_i == rs_idx) begin
          rdata_o[p*XLEN +: XLEN] = wd_i;
        end else begin
          rdata_o[p*XLEN +: XLEN] = mem[rs_idx];
          hazard_o[p]             = pend_q[rs_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one bypassing and one non-bypassing instance
// share the stimulus; a per-cycle expectation queue is drained by a monitor.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clear_i = 1'b0;
  logic            we_i = 1'b0;
  logic [AW-1:0]   rd_i = '0;
  logic [XLEN-1:0] wd_i = '0;
  logic            rsv_i = 1'b0;
  logic [AW-1:0]   rsv_rd_i = '0;
  logic [AW-1:0]   rs0 = '0, rs1 = '0;
  logic [2*AW-1:0] rs_i;

  logic              ready_b, ready_n;
  logic [2*XLEN-1:0] rdata_b, rdata_n;
  logic [1:0]        haz_b, haz_n;

  assign rs_i = {rs1, rs0};

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .clear_i(clear_i), .ready_o(ready_b),
    .rs_i(rs_i), .rdata_o(rdata_b), .hazard_o(haz_b),
    .we_i(we_i), .rd_i(rd_i), .wd_i(wd_i), .rsv_i(rsv_i), .rsv_rd_i(rsv_rd_i)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .clear_i(clear_i), .ready_o(ready_n),
    .rs_i(rs_i), .rdata_o(rdata_n), .hazard_o(haz_n),
    .we_i(we_i), .rd_i(rd_i), .wd_i(wd_i), .rsv_i(rsv_i), .rsv_rd_i(rsv_rd_i)
  );

  typedef struct {
    logic             ready;
    logic [1:0][31:0] rd_b;
    logic [1:0]       hz_b;
    logic [1:0][31:0] rd_n;
    logic [1:0]       hz_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural values, pending flags and a countdown of
  // edges remaining until the file becomes usable again.
  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_ready;
  int          m_cnt;

  function automatic void model_reset();
    m_ready = 1'b0;
    m_cnt   = NREGS - 1;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      model_reset();
    end else if (m_ready) begin
      if (clear_i) begin
        model_reset();
      end else begin
        if (we_i && rd_i != 0) begin
          m_regs[rd_i] = wd_i;
          m_pend[rd_i] = 1'b0;
        end
        if (rsv_i && rsv_rd_i != 0) m_pend[rsv_rd_i] = 1'b1;
      end
    end else if (clear_i) begin
      m_cnt = NREGS - 1;
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_ready = 1'b1;
    end
  endfunction

  function automatic exp_t model_outputs();
    exp_t        e;
    logic [4:0]  rs;
    e.ready = m_ready;
    for (int p = 0; p < 2; p++) begin
      rs = (p == 0) ? rs0 : rs1;
      e.rd_b[p] = '0; e.hz_b[p] = 1'b0;
      e.rd_n[p] = '0; e.hz_n[p] = 1'b0;
      if (m_ready && rs != 0) begin
        e.rd_n[p] = m_regs[rs];
        e.hz_n[p] = m_pend[rs];
        if (we_i && rd_i == rs) begin
          e.rd_b[p] = wd_i;
        end else begin
          e.rd_b[p] = m_regs[rs];
          e.hz_b[p] = m_pend[rs];
        end
      end
    end
    return e;
  endfunction

  task automatic drive(input logic rn, input logic clr, input logic we,
                       input logic [AW-1:0] rd, input logic [31:0] wd,
                       input logic rsv, input logic [AW-1:0] rsvrd,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(posedge clk);
    model_edge();
    #1;
    reset = rn; clear_i = clr; we_i = we; rd_i = rd; wd_i = wd;
    rsv_i = rsv; rsv_rd_i = rsvrd; rs0 = r0; rs1 = r1;
    if (!rn) model_reset();
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, r0, r1);
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ready_byp", 32'(ready_b), 32'(e.ready));
        chk("ready_nob", 32'(ready_n), 32'(e.ready));
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("rdata_byp%0d", p), rdata_b[p*XLEN +: XLEN], e.rd_b[p]);
          chk($sformatf("hazard_byp%0d", p), 32'(haz_b[p]), 32'(e.hz_b[p]));
          chk($sformatf("rdata_nob%0d", p), rdata_n[p*XLEN +: XLEN], e.rd_n[p]);
          chk($sformatf("hazard_nob%0d", p), 32'(haz_n[p]), 32'(e.hz_n[p]));
        end
      end
    end
  end

  initial begin : stim
    model_reset();
    // Reset held, release, full sweep while reading assorted indices.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd17);
    for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd2, pick(), pick());
    idle(5'd3, 5'd31, 2);

    // Plain write, index 0 write, same-cycle bypass.
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 5'd0, 5'd0);
    idle(5'd5, 5'd0, 1);
    drive(1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, 5'd0, 5'd5);
    idle(5'd0, 5'd5, 1);
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, 5'd5, 5'd7);
    idle(5'd7, 5'd7, 1);

    // Reserve, satisfying write, simultaneous reserve and write.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd9, 1);
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, '0, 5'd9, 5'd9);
    idle(5'd9, 5'd9, 1);
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0066, 1'b1, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9, 1);

    // Clear sweep with writes and reserves offered during it.
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0077, 1'b1, 5'd4, 5'd3, 5'd4);
    drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h1111_1111, 1'b1, 5'd6, 5'd3, 5'd4);
    for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 1'b1, 5'd3, $urandom, 1'b1, 5'd4, 5'd3, 5'd4);
    idle(5'd3, 5'd4, 2);

    // Reset mid-sweep, then reset with pending reservations outstanding.
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd2);
    idle(5'd1, 5'd2, 11);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd2);
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, pick(), pick());
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'hCAFE_F00D, 1'b1, 5'd10, 5'd8, 5'd10);
    idle(5'd8, 5'd10, 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd8, 5'd10);
    for (int i = 0; i < 33; i++) drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd8, 5'd10);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 399) != 0), ($urandom_range(0, 149) == 0),
            1'($urandom_range(0, 1)), pick(), $urandom,
            1'($urandom_range(0, 1)), pick(), pick(), pick());
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the Pillar core. It replaces the fixed 32x32, two-read, no-write decode-stage register bank. It adds:
- a write port with write-to-read bypass;
- NREAD generic read ports;
- a per-register pending-write scoreboard for hazard detection;
- a sequential clear sweep, so the storage array needs no reset and can map to RAM/LUTRAM.

It sits between instruction decode (read/reserve) and writeback (write).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=4); entry 0 reads as zero
NREAD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads see array only
AW (localparam), clog2(NREGS), register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
clear_i  in  1  synchronous request to re-zero all registers and the scoreboard
ready_o  out  1  high when the sweep is complete and the file is usable
rs_i  in  NREAD*AW  read indices, port p at bits [p*AW +: AW]
rdata_o  out  NREAD*XLEN  read data, port p at bits [p*XLEN +: XLEN], combinational
hazard_o  out  NREAD  port p source has an outstanding reservation, not satisfied this cycle
we_i  in  1  write enable
rd_i  in  AW  write index
wd_i  in  XLEN  write data
rsv_i  in  1  reserve destination (issued instruction will write rsv_rd_i)
rsv_rd_i  in  AW  reserved index

Behaviour:
- Reset: one clock, asynchronous, active-low; the polarity and synchronicity are fixed.
- Reset asserted (async):
  - state=CLEAR, idx=1, pend[]=0, ready_o=0.
  - Array contents are not reset.
- States: CLEAR and READY.
- CLEAR:
  - Each rising edge writes 0 to array[idx], clears pend[idx], and increments idx.
  - On the edge that writes idx==NREGS-1: go to READY and set ready_o=1.
  - ready_o therefore rises NREGS-1 edges after reset deassertion (31 by default).
- CLEAR, inputs and outputs:
  - we_i and rsv_i are ignored.
  - rdata_o=0 and hazard_o=0 on all ports.
  - clear_i restarts the sweep at idx=1.
- READY:
  - clear_i=1 → next edge: state=CLEAR, idx=1, ready_o=0, pend[]=0.
  - A write or reserve presented in that same cycle is dropped.
- Write, READY: we_i && rd_i!=0 → array[rd_i]<=wd_i and pend[rd_i]<=0 at the edge. Writes to index 0 are discarded.
- Reserve, READY: rsv_i && rsv_rd_i!=0 → pend[rsv_rd_i]<=1. Reserve of index 0 is ignored.
- Simultaneous write and reserve of the same index: pend ends at 1 (new producer wins); array is still written.
- Read port p, combinational:
  - rs==0 → rdata 0, hazard 0.
  - Else if BYPASS && we_i && rd_i==rs → rdata=wd_i, hazard 0.
  - Else → rdata=array[rs], hazard=pend[rs].
- Read port p with BYPASS=0 and a same-cycle matching write: rdata returns the old value; hazard reflects pend before the edge.
- Latency: write-to-read is 0 cycles with BYPASS=1, 1 cycle otherwise. Reserve-to-hazard is 1 cycle.
- Multiple read ports may address the same index with no restriction.
- No X may appear on rdata_o after ready_o=1.

Test Plan:
1. Reset low 3 cycles, then release → ready_o=0 for 31 edges, 1 after edge 31; every rs reads 0x00000000 both before and after.
2. Write r5=0xDEADBEEF, next cycle rs0=5, rs1=0 → rdata0=0xDEADBEEF, rdata1=0. Write r0=0x1234 → r0 still reads 0.
3. BYPASS=1: we_i, rd_i=7, wd_i=0xA5A5A5A5 with rs1=7 in the same cycle → rdata1=0xA5A5A5A5 combinationally. Repeat with BYPASS=0 → old value (0).
4. rsv r9, next cycle rs0=9 → hazard0=1. Then write r9=0x55 → hazard0=0 in the same cycle, rdata0=0x55. Reserve+write r9 together → hazard stays 1 next cycle.
5. Write r3=0x77, reserve r4, assert clear_i one cycle → ready_o=0 next cycle. After 31 edges: r3 reads 0, hazard for r4=0. Writes issued during the sweep have no effect.
6. Assert reset mid-sweep (idx≈12) and mid-operation with pend set → ready_o drops immediately, pend cleared, sweep restarts from idx=1 and completes in 31 edges.
